// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic ops plus an iterative shift-add multiplier.
// Results, flags and the done pulse are all registered.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] sign_extend,
    input  logic             ALU_Src,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       alu_funct,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ZERO,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_MUL  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_ILL = 3'd6;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic [2:0]         dec_op;
    logic [WIDTH-1:0]   opb;
    logic               accept;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   ex_res;
    logic               ex_ovf, ex_ill;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;

    assign opb    = ALU_Src ? sign_extend : read_data2;
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        dec_op = OP_ILL;
        case (alu_op)
            2'b00:   dec_op = OP_ADD;
            2'b01:   dec_op = OP_SUB;
            default: begin
                case (alu_funct)
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b101010: dec_op = OP_SLT;
                    6'b011000: dec_op = (MUL_EN != 0) ? OP_MUL : OP_ILL;
                    default:   dec_op = OP_ILL;
                endcase
            end
        endcase
    end

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        ex_res = '0;
        ex_ovf = 1'b0;
        ex_ill = 1'b0;
        case (op_q)
            OP_ADD: begin
                ex_res = sum;
                ex_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res = diff;
                ex_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  ex_res = a_q & b_q;
            OP_OR:   ex_res = a_q | b_q;
            OP_SLT:  ex_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default: ex_ill = 1'b1;
        endcase
    end

    // Accumulator starts as {0, B}; each step adds A to the high half when
    // the current multiplier bit is set, then shifts the whole thing right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        case (state_q)
            S_EXEC: begin
                res_d   = ex_res;
                zero_d  = (ex_res == '0);
                ovf_d   = ex_ovf;
                ill_d   = ex_ill;
                state_d = S_DONE;
            end
            S_MUL: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = acc_nxt[WIDTH-1:0];
                    zero_d  = (acc_nxt[WIDTH-1:0] == '0);
                    ovf_d   = |acc_nxt[2*WIDTH-1:WIDTH];
                    ill_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (accept) begin
                    op_d  = dec_op;
                    a_d   = read_data1;
                    b_d   = opb;
                    acc_d = {{WIDTH{1'b0}}, opb};
                    cnt_d = '0;
                    state_d = (dec_op == OP_MUL) ? S_MUL : S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign busy     = (state_q == S_EXEC) || (state_q == S_MUL);
    assign done     = (state_q == S_DONE);
    assign result   = res_q;
    assign ZERO     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule
